commit_stage: RTL and testbench

COMMIT_STAGE -- requirements
Module: commit_stage

---
 rtl/commit_stage.sv | 148 ++++++++++++++
 tb/tb_commit_stage.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/commit_stage.sv
// rtl/commit_stage.sv - single-entry commit register stage with exception/ertn redirect and retire counter
module commit_stage #(
    parameter logic [5:0]  ECODE_INE = 6'h0D,
    parameter logic [31:0] RESET_PC  = 32'h1c000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic [4:0]  in_rd,
    input  logic        in_we,
    input  logic [31:0] in_wdata,
    input  logic        in_inv,
    input  logic        in_ex,
    input  logic [5:0]  in_ecode,
    input  logic [8:0]  in_esubcode,
    input  logic        in_ertn,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        cmt_valid,
    output logic [31:0] cmt_pc,
    output logic [31:0] cmt_inst,
    output logic        cmt_inv,
    output logic        cmt_ex,
    output logic        cmt_ertn,
    output logic [5:0]  cmt_ecode,
    output logic [8:0]  cmt_esubcode,
    output logic [31:0] cmt_ex_pc,
    output logic [63:0] instret
);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t      state;
    state_t      state_next;
    logic        transfer;
    logic        eff_ex;
    logic        eff_ertn;
    logic [5:0]  eff_ecode;
    logic [8:0]  eff_esubcode;
    logic        cap_we;
    logic [4:0]  cap_rd;
    logic [31:0] cap_wdata;

    assign transfer = in_valid && in_ready;

    // Resolve the effective exception: a real exception wins over an invalid-instruction
    // substitution, and any exception suppresses ertn.
    always_comb begin
        eff_ex       = in_ex || in_inv;
        eff_ecode    = ECODE_INE;
        eff_esubcode = 9'd0;
        if (in_ex) begin
            eff_ecode    = in_ecode;
            eff_esubcode = in_esubcode;
        end
        eff_ertn = in_ertn && !eff_ex;
    end

    // State register: DRAIN lasts one cycle after every redirect.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, handshake and redirect outputs; target is forced to zero when not flushing.
    always_comb begin
        state_next   = state;
        in_ready     = 1'b0;
        flush        = 1'b0;
        flush_target = 32'd0;
        case (state)
            RUN: begin
                in_ready = 1'b1;
                flush    = cmt_valid && (cmt_ex || cmt_ertn);
                if (flush) begin
                    state_next   = DRAIN;
                    flush_target = cmt_ex ? csr_eentry : csr_era;
                end
            end
            DRAIN: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Capture the accepted instruction; without a transfer only cmt_valid drops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cmt_valid    <= 1'b0;
            cmt_pc       <= RESET_PC;
            cmt_inst     <= 32'd0;
            cmt_inv      <= 1'b0;
            cmt_ex       <= 1'b0;
            cmt_ertn     <= 1'b0;
            cmt_ecode    <= 6'd0;
            cmt_esubcode <= 9'd0;
            cmt_ex_pc    <= RESET_PC;
            cap_we       <= 1'b0;
            cap_rd       <= 5'd0;
            cap_wdata    <= 32'd0;
        end else begin
            cmt_valid <= transfer;
            if (transfer) begin
                cmt_pc       <= in_pc;
                cmt_inst     <= in_inst;
                cmt_inv      <= in_inv;
                cmt_ex       <= eff_ex;
                cmt_ertn     <= eff_ertn;
                cmt_ecode    <= eff_ex ? eff_ecode : 6'd0;
                cmt_esubcode <= eff_ex ? eff_esubcode : 9'd0;
                cap_we       <= in_we;
                cap_rd       <= in_rd;
                cap_wdata    <= in_wdata;
                if (eff_ex || eff_ertn) begin
                    cmt_ex_pc <= in_pc;
                end
            end
        end
    end

    assign rf_waddr = cap_rd;
    assign rf_wdata = cap_wdata;
    assign rf_we    = cmt_valid && cap_we && !cmt_ex && (cap_rd != 5'd0);

    // Retire counter: every committed non-exception instruction, ertn included.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret <= 64'd0;
        end else if (cmt_valid && !cmt_ex) begin
            instret <= instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_commit_stage.sv
// tb/tb_commit_stage.sv - directed self-checking bench for commit_stage
module tb_commit_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic [4:0]  in_rd;
    logic        in_we;
    logic [31:0] in_wdata;
    logic        in_inv;
    logic        in_ex;
    logic [5:0]  in_ecode;
    logic [8:0]  in_esubcode;
    logic        in_ertn;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        flush;
    logic [31:0] flush_target;
    logic        cmt_valid;
    logic [31:0] cmt_pc;
    logic [31:0] cmt_inst;
    logic        cmt_inv;
    logic        cmt_ex;
    logic        cmt_ertn;
    logic [5:0]  cmt_ecode;
    logic [8:0]  cmt_esubcode;
    logic [31:0] cmt_ex_pc;
    logic [63:0] instret;

    int tests = 0;
    int fails = 0;

    commit_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst), .in_rd(in_rd), .in_we(in_we), .in_wdata(in_wdata),
        .in_inv(in_inv), .in_ex(in_ex), .in_ecode(in_ecode), .in_esubcode(in_esubcode),
        .in_ertn(in_ertn), .csr_eentry(csr_eentry), .csr_era(csr_era),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_target(flush_target),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst), .cmt_inv(cmt_inv),
        .cmt_ex(cmt_ex), .cmt_ertn(cmt_ertn), .cmt_ecode(cmt_ecode), .cmt_esubcode(cmt_esubcode),
        .cmt_ex_pc(cmt_ex_pc), .instret(instret)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [4:0] rd, input logic we,
                         input logic [31:0] wdata, input logic inv, input logic ex,
                         input logic [5:0] ecode, input logic [8:0] esub, input logic ertn);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_inst     = pc ^ 32'h00a00513;
        in_rd       = rd;
        in_we       = we;
        in_wdata    = wdata;
        in_inv      = inv;
        in_ex       = ex;
        in_ecode    = ecode;
        in_esubcode = esub;
        in_ertn     = ertn;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_inst = '0; in_rd = '0; in_we = 1'b0; in_wdata = '0;
        in_inv = 1'b0; in_ex = 1'b0; in_ecode = '0; in_esubcode = '0; in_ertn = 1'b0;
        csr_eentry = 32'h1c008000;
        csr_era    = 32'h1c000104;
        #1;
        check("rst_cmt_valid", cmt_valid, 0);
        check("rst_cmt_pc", cmt_pc, 32'h1c000000);
        check("rst_cmt_ex_pc", cmt_ex_pc, 32'h1c000000);
        check("rst_cmt_inst", cmt_inst, 0);
        check("rst_instret", instret, 0);
        check("rst_flush", flush, 0);
        check("rst_rf_we", rf_we, 0);
        #11;
        reset = 1'b0;
        check("post_rst_in_ready", in_ready, 1);

        // ALU op with register write
        drive(32'h1c000010, 5'd5, 1'b1, 32'h0000ABCD, 1'b0, 1'b0, 6'h0, 9'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("alu_cmt_valid", cmt_valid, 1);
        check("alu_cmt_pc", cmt_pc, 32'h1c000010);
        check("alu_cmt_inst", cmt_inst, 32'h1ca00503);
        check("alu_rf_we", rf_we, 1);
        check("alu_rf_waddr", rf_waddr, 5);
        check("alu_rf_wdata", rf_wdata, 32'h0000ABCD);
        check("alu_instret_before", instret, 0);
        check("alu_flush", flush, 0);
        tick();
        check("alu_instret_after", instret, 1);
        check("alu_idle_valid", cmt_valid, 0);
        check("alu_idle_rf_we", rf_we, 0);

        // Exception from upstream
        drive(32'h1c000020, 5'd3, 1'b1, 32'h1234, 1'b0, 1'b1, 6'h0B, 9'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("ex_cmt_ex", cmt_ex, 1);
        check("ex_cmt_ecode", cmt_ecode, 6'h0B);
        check("ex_cmt_ex_pc", cmt_ex_pc, 32'h1c000020);
        check("ex_flush", flush, 1);
        check("ex_flush_target", flush_target, 32'h1c008000);
        check("ex_rf_we", rf_we, 0);
        check("ex_in_ready_flush_cycle", in_ready, 1);
        tick();
        check("ex_drain_in_ready", in_ready, 0);
        check("ex_drain_flush", flush, 0);
        check("ex_drain_target", flush_target, 0);
        check("ex_instret", instret, 1);
        drive(32'h1c0000F0, 5'd7, 1'b1, 32'hDEAD, 1'b0, 1'b0, 6'h0, 9'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("drain_ignored_valid", cmt_valid, 0);
        check("drain_ignored_rf_we", rf_we, 0);
        check("drain_exit_in_ready", in_ready, 1);
        check("drain_ex_pc_held", cmt_ex_pc, 32'h1c000020);

        // Exception return
        drive(32'h1c000030, 5'd0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0, 9'h0, 1'b1);
        tick();
        in_valid = 1'b0;
        check("ertn_flush", flush, 1);
        check("ertn_flush_target", flush_target, 32'h1c000104);
        check("ertn_cmt_ertn", cmt_ertn, 1);
        check("ertn_cmt_ex", cmt_ex, 0);
        check("ertn_cmt_ex_pc", cmt_ex_pc, 32'h1c000030);
        tick();
        check("ertn_instret", instret, 2);
        check("ertn_drain_in_ready", in_ready, 0);
        tick();

        // Invalid instruction becomes INE exception
        drive(32'h1c000040, 5'd4, 1'b1, 32'h55, 1'b1, 1'b0, 6'h05, 9'h1FF, 1'b0);
        tick();
        in_valid = 1'b0;
        check("inv_cmt_ex", cmt_ex, 1);
        check("inv_cmt_ecode", cmt_ecode, 6'h0D);
        check("inv_cmt_esubcode", cmt_esubcode, 0);
        check("inv_cmt_inv", cmt_inv, 1);
        check("inv_rf_we", rf_we, 0);
        check("inv_flush_target", flush_target, 32'h1c008000);
        tick();
        tick();
        check("inv_instret", instret, 2);

        // Exception and ertn together: exception wins
        drive(32'h1c000050, 5'd0, 1'b0, 32'h0, 1'b0, 1'b1, 6'h08, 9'h001, 1'b1);
        tick();
        in_valid = 1'b0;
        check("exertn_cmt_ertn", cmt_ertn, 0);
        check("exertn_cmt_ex", cmt_ex, 1);
        check("exertn_cmt_ecode", cmt_ecode, 6'h08);
        check("exertn_cmt_esubcode", cmt_esubcode, 9'h001);
        check("exertn_flush_target", flush_target, 32'h1c008000);
        tick();
        tick();
        check("exertn_instret", instret, 2);

        // Asynchronous reset between edges while an instruction is committing
        drive(32'h1c000060, 5'd9, 1'b1, 32'h77, 1'b0, 1'b0, 6'h0, 9'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        check("arst_pre_valid", cmt_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_cmt_valid", cmt_valid, 0);
        check("arst_instret", instret, 0);
        check("arst_flush", flush, 0);
        check("arst_rf_we", rf_we, 0);
        check("arst_cmt_pc", cmt_pc, 32'h1c000000);
        #2;
        reset = 1'b0;
        check("arst_in_ready", in_ready, 1);
        tick();
        check("arst_no_retire", instret, 0);
        check("arst_no_flush", flush, 0);

        // Eight back-to-back ops targeting r0
        for (int i = 0; i < 8; i++) begin
            drive(32'h1c000100 + 32'(i * 4), 5'd0, 1'b1, 32'(i), 1'b0, 1'b0, 6'h0, 9'h0, 1'b0);
            tick();
            check("burst_cmt_valid", cmt_valid, 1);
            check("burst_rf_we", rf_we, 0);
            check("burst_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        tick();
        check("burst_instret", instret, 8);
        check("burst_idle_valid", cmt_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
